// File: rtl/spi_master_cfg_if.sv
// Bundle between the SPI master and its environment.
// Host side: i_start / i_tx_data / i_ss_sel / i_cpol / i_cpha / i_lsb_first /
//   i_clk_div in, o_busy / o_rx_valid / o_rx_data out.
// Pin side: o_sck / o_mosi / o_ss_n out, i_miso in.
// Modport master is the SPI master block; modport slave is everything around it.
interface spi_master_cfg_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  parameter int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
);
  logic              i_start;
  logic [DATA_W-1:0] i_tx_data;
  logic [SS_W-1:0]   i_ss_sel;
  logic              i_cpol;
  logic              i_cpha;
  logic              i_lsb_first;
  logic [DIV_W-1:0]  i_clk_div;
  logic              o_busy;
  logic              o_rx_valid;
  logic [DATA_W-1:0] o_rx_data;
  logic              o_sck;
  logic              o_mosi;
  logic              i_miso;
  logic [NUM_SS-1:0] o_ss_n;

  modport master (
    input  i_start, i_tx_data, i_ss_sel, i_cpol, i_cpha, i_lsb_first, i_clk_div, i_miso,
    output o_busy, o_rx_valid, o_rx_data, o_sck, o_mosi, o_ss_n
  );

  modport slave (
    output i_start, i_tx_data, i_ss_sel, i_cpol, i_cpha, i_lsb_first, i_clk_div, i_miso,
    input  o_busy, o_rx_valid, o_rx_data, o_sck, o_mosi, o_ss_n
  );
endinterface

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: per-transfer CPOL/CPHA, bit order, SCK divider and
// one-hot active-low slave select.
// Ports:
//   i_clk   - system clock, everything on posedge
//   i_rst_n - asynchronous active-low reset
//   bus     - spi_master_cfg_if.master: host request/response and SPI pins
// Sequence: IDLE -> LEAD (H) -> XFER (2*DATA_W*H) -> TRAIL (H) -> DONE (1) -> IDLE,
// with H = i_clk_div+1 i_clk cycles per SCK half-period. All outputs registered.
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  spi_master_cfg_if.master bus
);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              phase, phase_nxt;      // 0: next SCK edge is leading
  logic              sck_q, sck_nxt;
  logic              mosi_q, mosi_nxt;
  logic [NUM_SS-1:0] ss_n_q, ss_n_nxt;
  logic              busy_q, busy_nxt;
  logic              rx_valid_q, rx_valid_nxt;
  logic [DATA_W-1:0] rx_data_q, rx_data_nxt;
  logic              cpol_q, cpol_nxt;

  logic [DATA_W-1:0] tx_sh, tx_sh_nxt;
  logic [DATA_W-1:0] rx_sh, rx_sh_nxt;
  logic              cpha_q, cpha_nxt;
  logic              lsb_q, lsb_nxt;
  logic [DIV_W-1:0]  div_q, div_nxt;

  logic              accept;
  logic              tick;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  // Bit that goes on MOSI next, given the current shift-register contents.
  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  assign accept   = bus.i_start && (int'(bus.i_ss_sel) < NUM_SS);
  assign tick     = (div_cnt == div_q);
  assign tx_shift = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
  assign rx_shift = lsb_q ? {bus.i_miso, rx_sh[DATA_W-1:1]}
                          : {rx_sh[DATA_W-2:0], bus.i_miso};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    bit_cnt_nxt  = bit_cnt;
    phase_nxt    = phase;
    sck_nxt      = sck_q;
    mosi_nxt     = mosi_q;
    ss_n_nxt     = ss_n_q;
    busy_nxt     = busy_q;
    rx_valid_nxt = 1'b0;
    rx_data_nxt  = rx_data_q;
    cpol_nxt     = cpol_q;
    tx_sh_nxt    = tx_sh;
    rx_sh_nxt    = rx_sh;
    cpha_nxt     = cpha_q;
    lsb_nxt      = lsb_q;
    div_nxt      = div_q;

    case (state)
      IDLE: begin
        div_cnt_nxt = '0;
        bit_cnt_nxt = BIT_LAST;
        phase_nxt   = 1'b0;
        if (accept) begin
          state_nxt = LEAD;
          busy_nxt  = 1'b1;
          cpol_nxt  = bus.i_cpol;
          cpha_nxt  = bus.i_cpha;
          lsb_nxt   = bus.i_lsb_first;
          div_nxt   = bus.i_clk_div;
          tx_sh_nxt = bus.i_tx_data;
          sck_nxt   = bus.i_cpol;
          mosi_nxt  = first_bit(bus.i_tx_data, bus.i_lsb_first);
          ss_n_nxt  = '1;
          for (int i = 0; i < NUM_SS; i++) begin
            if (int'(bus.i_ss_sel) == i) ss_n_nxt[i] = 1'b0;
          end
        end
      end

      LEAD: begin
        if (tick) begin
          div_cnt_nxt = '0;
          state_nxt   = XFER;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      XFER: begin
        if (!tick) begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end else begin
          div_cnt_nxt = '0;
          sck_nxt     = ~sck_q;
          phase_nxt   = ~phase;
          if (!phase) begin
            // Leading edge: sample in mode CPHA=0, otherwise shift out (not before bit 0).
            if (!cpha_q) begin
              rx_sh_nxt = rx_shift;
            end else if (bit_cnt != BIT_LAST) begin
              tx_sh_nxt = tx_shift;
              mosi_nxt  = first_bit(tx_shift, lsb_q);
            end
          end else begin
            // Trailing edge closes a bit: sample for CPHA=1, shift out for CPHA=0.
            if (cpha_q) begin
              rx_sh_nxt = rx_shift;
            end else if (bit_cnt != '0) begin
              tx_sh_nxt = tx_shift;
              mosi_nxt  = first_bit(tx_shift, lsb_q);
            end
            if (bit_cnt == '0) state_nxt = TRAIL;
            else               bit_cnt_nxt = bit_cnt - BIT_W'(1);
          end
        end
      end

      TRAIL: begin
        sck_nxt = cpol_q;
        if (tick) begin
          div_cnt_nxt  = '0;
          state_nxt    = DONE;
          ss_n_nxt     = '1;
          rx_valid_nxt = 1'b1;
          rx_data_nxt  = rx_sh;
          mosi_nxt     = 1'b0;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt    <= '0;
      bit_cnt    <= BIT_LAST;
      phase      <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cpol_q     <= 1'b0;
    end else begin
      div_cnt    <= div_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      phase      <= phase_nxt;
      sck_q      <= sck_nxt;
      mosi_q     <= mosi_nxt;
      ss_n_q     <= ss_n_nxt;
      busy_q     <= busy_nxt;
      rx_valid_q <= rx_valid_nxt;
      rx_data_q  <= rx_data_nxt;
      cpol_q     <= cpol_nxt;
    end
  end

  // Shift registers and per-transfer settings are always reloaded before use.
  always_ff @(posedge i_clk) begin
    tx_sh  <= tx_sh_nxt;
    rx_sh  <= rx_sh_nxt;
    cpha_q <= cpha_nxt;
    lsb_q  <= lsb_nxt;
    div_q  <= div_nxt;
  end

  assign bus.o_sck      = sck_q;
  assign bus.o_mosi     = mosi_q;
  assign bus.o_ss_n     = ss_n_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_rx_data  = rx_data_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
module tb_spi_master_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_master_cfg_if #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) bus ();
  spi_master_cfg #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  // Wide instance; NUM_SS=3 leaves select code 3 out of range on a 2-bit select.
  spi_master_cfg_if #(.DATA_W(16), .NUM_SS(3), .DIV_W(8)) bus16 ();
  spi_master_cfg #(.DATA_W(16), .NUM_SS(3), .DIV_W(8)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus16));

  bit         tb_loop = 1'b1;
  logic [7:0] tb_slave = 8'h00;
  logic       slave_miso = 1'b0;
  assign bus.i_miso   = tb_loop ? bus.o_mosi : slave_miso;
  assign bus16.i_miso = bus16.o_mosi;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  bit         m_act = 0;
  int         m_k, m_H, m_N, m_sel;
  logic [7:0] m_tx, m_slw, m_exp_rx;
  logic [7:0] m_rxd = 8'h00;
  logic       m_cpol = 1'b0, m_cpha, m_lsb;

  initial begin
    logic [3:0] e_ssn;
    logic       e_busy, e_sck, e_mosi, e_vld;
    int         e, idx;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_act = 0; m_cpol = 1'b0; m_rxd = 8'h00;
      end else if (m_act) begin
        m_k++;
        if (m_k == m_N + 1) m_act = 0;
      end else if (bus.i_start && int'(bus.i_ss_sel) < 4) begin
        m_act  = 1; m_k = 0;
        m_H    = int'(bus.i_clk_div) + 1;
        m_N    = 18 * m_H;
        m_tx   = bus.i_tx_data; m_sel = int'(bus.i_ss_sel);
        m_cpol = bus.i_cpol; m_cpha = bus.i_cpha; m_lsb = bus.i_lsb_first;
        m_slw  = tb_slave;
        m_exp_rx = tb_loop ? bus.i_tx_data : tb_slave;
      end
      #1;
      if (m_act && m_k == m_N) m_rxd = m_exp_rx;
      e_ssn = 4'hF; e_busy = 1'b0; e_vld = 1'b0; e_sck = m_cpol; e_mosi = 1'b0;
      slave_miso = 1'b0;
      if (m_act && m_k < m_N) begin
        // e = SCK edges already on the pin: first edge H cycles into XFER.
        e = m_k / m_H - 1;
        if (e < 0) e = 0;
        if (e > 16) e = 16;
        e_sck = m_cpol ^ (e % 2 == 1);
        if (m_cpha) idx = (e <= 1) ? 0 : (e - 1) / 2;
        else        idx = e / 2;
        if (idx > 7) idx = 7;
        e_mosi     = m_lsb ? m_tx[idx]  : m_tx[7-idx];
        slave_miso = m_lsb ? m_slw[idx] : m_slw[7-idx];
        e_busy = 1'b1;
        e_ssn[m_sel] = 1'b0;
      end else if (m_act) begin
        e_busy = 1'b1; e_vld = 1'b1;
      end
      chk("mon_busy", bus.o_busy, e_busy);
      chk("mon_ss_n", bus.o_ss_n, e_ssn);
      chk("mon_sck", bus.o_sck, e_sck);
      chk("mon_mosi", bus.o_mosi, e_mosi);
      chk("mon_rx_valid", bus.o_rx_valid, e_vld);
      chk("mon_rx_data", bus.o_rx_data, m_rxd);
    end
  end

  // ---------------- one transfer on the 8-bit instance, with measurements ----------------
  task automatic run_xfer(input logic [7:0] tx, input logic [1:0] sel,
                          input logic cpol, input logic cpha, input logic lsb,
                          input logic [7:0] div, input bit loop, input logic [7:0] slw,
                          output int lat, output int blow, output int rises, output int falls,
                          output logic [7:0] rbits, output logic [7:0] rdata,
                          output logic sck0, output logic sckend,
                          output logic [3:0] ss0, output logic [3:0] ssv,
                          output int mingap, output int maxgap);
    logic prev;
    int   lastk;
    @(negedge clk);
    bus.i_tx_data = tx; bus.i_ss_sel = sel; bus.i_cpol = cpol; bus.i_cpha = cpha;
    bus.i_lsb_first = lsb; bus.i_clk_div = div; tb_loop = loop; tb_slave = slw;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat = -1; blow = -1; rises = 0; falls = 0; rbits = 8'h00; rdata = 8'h00;
    mingap = 1 << 30; maxgap = 0; lastk = -1; sckend = 1'b0; ssv = 4'h0;
    sck0 = bus.o_sck; ss0 = bus.o_ss_n; prev = sck0;
    for (int k = 0; k < 20000; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (bus.o_sck !== prev) begin
          if (bus.o_sck) begin rises++; rbits = {rbits[6:0], bus.o_mosi}; end
          else falls++;
          if (lastk >= 0) begin
            if (k - lastk < mingap) mingap = k - lastk;
            if (k - lastk > maxgap) maxgap = k - lastk;
          end
          lastk = k; prev = bus.o_sck;
        end
      end
      if (bus.o_rx_valid && lat < 0) begin lat = k; rdata = bus.o_rx_data; ssv = bus.o_ss_n; end
      if (!bus.o_busy) begin blow = k; sckend = bus.o_sck; break; end
    end
    chk("xfer_finished_in_budget", blow >= 0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish actual=running required=done");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int lat, blow, rises, falls, mingap, maxgap;
    logic [7:0] rbits, rdata, tx, slw, div;
    logic sck0, sckend;
    logic [3:0] ss0, ssv;
    bus.i_start = 0; bus.i_tx_data = 0; bus.i_ss_sel = 0; bus.i_cpol = 0;
    bus.i_cpha = 0; bus.i_lsb_first = 0; bus.i_clk_div = 0;
    bus16.i_start = 0; bus16.i_tx_data = 0; bus16.i_ss_sel = 0; bus16.i_cpol = 0;
    bus16.i_cpha = 0; bus16.i_lsb_first = 0; bus16.i_clk_div = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", bus.o_ss_n, 4'hF);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_sck", bus.o_sck, 1'b0);
    chk("rst_mosi", bus.o_mosi, 1'b0);
    chk("rst_rx_valid", bus.o_rx_valid, 1'b0);
    chk("rst_rx_data", bus.o_rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, MSB first, div 0, slave answers 0x3C.
    run_xfer(8'hA5, 2'd0, 0, 0, 0, 8'd0, 0, 8'h3C,
             lat, blow, rises, falls, rbits, rdata, sck0, sckend, ss0, ssv, mingap, maxgap);
    chk("t1_rx_valid_offset", lat, 18);
    chk("t1_rx_data", rdata, 8'h3C);
    chk("t1_mosi_at_rise", rbits, 8'b1010_0101);
    chk("t1_ss_n_at_done", ssv, 4'b1111);

    // Every mode and bit order, loopback.
    for (int m = 0; m < 8; m++) begin
      run_xfer(8'h81, 2'(m % 4), m[0], m[1], m[2], 8'd0, 1, 8'h00,
               lat, blow, rises, falls, rbits, rdata, sck0, sckend, ss0, ssv, mingap, maxgap);
      chk("t2_loop_rx", rdata, 8'h81);
      chk("t2_rises", rises, 8);
      chk("t2_falls", falls, 8);
      chk("t2_sck_idle_lead", sck0, 1'(m[0]));
      chk("t2_sck_idle_after", sckend, 1'(m[0]));
    end

    // div 3 on select 2.
    run_xfer(8'h6B, 2'd2, 0, 0, 0, 8'd3, 1, 8'h00,
             lat, blow, rises, falls, rbits, rdata, sck0, sckend, ss0, ssv, mingap, maxgap);
    chk("t3_rx_valid_offset", lat, 72);
    chk("t3_busy_low_offset", blow, 73);
    chk("t3_ss_n_lead", ss0, 4'b1011);
    chk("t3_min_half_period", mingap, 4);
    chk("t3_max_half_period", maxgap, 4);
    chk("t3_rx", rdata, 8'h6B);

    // Start held high across two transfers.
    begin
      int nvld, nlow;
      bit seen2;
      logic [7:0] d1, d2;
      nvld = 0; nlow = 0; seen2 = 0; d1 = 0; d2 = 0;
      @(negedge clk);
      bus.i_tx_data = 8'h11; bus.i_ss_sel = 1; bus.i_cpol = 0; bus.i_cpha = 0;
      bus.i_lsb_first = 0; bus.i_clk_div = 0; tb_loop = 1; bus.i_start = 1;
      @(negedge clk);
      bus.i_tx_data = 8'h22;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (bus.o_rx_valid) begin
          if (nvld == 0) d1 = bus.o_rx_data; else d2 = bus.o_rx_data;
          nvld++;
        end
        if (!bus.o_busy) begin
          if (seen2) break;
          nlow++;
        end else if (nlow > 0 && !seen2) begin
          seen2 = 1; bus.i_start = 0;
        end
      end
      bus.i_start = 0;
      repeat (5) begin
        @(negedge clk);
        if (bus.o_rx_valid) nvld++;
      end
      chk("t4_rx_valid_pulses", nvld, 2);
      chk("t4_idle_gap_cycles", nlow, 1);
      chk("t4_first_word", d1, 8'h11);
      chk("t4_second_word", d2, 8'h22);
    end

    // Reset in the middle of XFER.
    begin
      int edges;
      logic prev;
      int nvld;
      edges = 0; nvld = 0;
      @(negedge clk);
      bus.i_tx_data = 8'hC3; bus.i_ss_sel = 3; bus.i_cpol = 0; bus.i_cpha = 0;
      bus.i_lsb_first = 0; bus.i_clk_div = 1; tb_loop = 1; bus.i_start = 1;
      @(negedge clk);
      bus.i_start = 0;
      prev = bus.o_sck;
      for (int c = 0; c < 100 && edges < 5; c++) begin
        @(negedge clk);
        if (bus.o_sck !== prev) begin edges++; prev = bus.o_sck; end
      end
      chk("t5_reached_5_edges", edges, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_ss_n", bus.o_ss_n, 4'hF);
      chk("t5_async_sck", bus.o_sck, 1'b0);
      chk("t5_async_busy", bus.o_busy, 1'b0);
      chk("t5_async_rx_valid", bus.o_rx_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) begin
        @(negedge clk);
        if (bus.o_rx_valid) nvld++;
      end
      chk("t5_no_rx_valid_after_abort", nvld, 0);
      run_xfer(8'h5A, 2'd0, 0, 0, 0, 8'd0, 1, 8'h00,
               lat, blow, rises, falls, rbits, rdata, sck0, sckend, ss0, ssv, mingap, maxgap);
      chk("t5_recovery_rx", rdata, 8'h5A);
    end

    // Randomized transfers.
    for (int i = 0; i < 30; i++) begin
      tx  = 8'($urandom);
      slw = 8'($urandom);
      div = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 7)) : 8'($urandom_range(0, 2));
      run_xfer(tx, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
               div, bit'($urandom), slw,
               lat, blow, rises, falls, rbits, rdata, sck0, sckend, ss0, ssv, mingap, maxgap);
      chk("rand_rx", rdata, tb_loop ? tx : slw);
      chk("rand_rx_valid_offset", lat, 18 * (int'(div) + 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // 16-bit instance: out-of-range select, then slow loopback.
    begin
      int k16;
      logic [15:0] r16;
      @(negedge clk);
      bus16.i_ss_sel = 2'd3; bus16.i_tx_data = 16'h1234; bus16.i_start = 1;
      repeat (6) begin
        @(negedge clk);
        chk("t6_bad_sel_busy", bus16.o_busy, 1'b0);
        chk("t6_bad_sel_ss_n", bus16.o_ss_n, 3'b111);
      end
      bus16.i_tx_data = 16'hBEEF; bus16.i_ss_sel = 2'd1; bus16.i_cpol = 1;
      bus16.i_cpha = 1; bus16.i_lsb_first = 1; bus16.i_clk_div = 8'd255;
      @(negedge clk);
      bus16.i_start = 0;
      chk("t6_ss_n_lead", bus16.o_ss_n, 3'b101);
      k16 = -1; r16 = 16'h0;
      for (int k = 0; k < 10000; k++) begin
        if (bus16.o_rx_valid) begin k16 = k; r16 = bus16.o_rx_data; break; end
        @(negedge clk);
      end
      chk("t6_rx_valid_offset", k16, 34 * 256);
      chk("t6_rx_data", r16, 16'hBEEF);
      @(negedge clk);
      chk("t6_busy_low_after_done", bus16.o_busy, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
